// File: rtl/entry_pkg.sv
// entry_pkg
// Shared definitions for the operand-entry front end: the FSM state
// encoding (also driven out on the phase LEDs) and the phase width.
package entry_pkg;

    localparam int PHASE_W = 2;

    // Encoding is visible on the board LEDs, so values are fixed.
    typedef enum logic [PHASE_W-1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        READY  = 2'd2,
        UNUSED = 2'd3
    } phase_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce
// Synchronizes one raw push-button into the clk domain, debounces it and
// produces a single-cycle pulse for each accepted press. Releases do not
// produce a pulse.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   btn    in   raw, bouncy, active-high button
//   level  out  debounced button level
//   press  out  one-cycle pulse on each accepted rising level change
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            // two-flop synchronizer
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            level_d <= level;
            // The counter holds the length of the current disagreement run;
            // the level flips on the sample that would bring it to
            // DEBOUNCE_CYCLES, so the counter never has to store that value.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/operand_entry.sv
// operand_entry
// Front end of the lab adder datapath. Synchronizes the slide switches,
// debounces the enter/clear buttons and sequences operand entry:
// A first, then B together with Cin and S.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sw[3:0]    in   raw operand switches
//   cin_sw     in   raw carry-in switch
//   sel_sw     in   raw output-select switch (1 = carry, 0 = sum)
//   btn_enter  in   raw enter button
//   btn_clear  in   raw clear button
//   A[3:0]     out  captured operand A
//   B[3:0]     out  captured operand B
//   Cin        out  captured carry-in
//   S          out  captured select
//   valid      out  high while A, B, Cin, S form a complete set
//   phase[1:0] out  current FSM state
module operand_entry
    import entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         sw,
    input  logic               cin_sw,
    input  logic               sel_sw,
    input  logic               btn_enter,
    input  logic               btn_clear,
    output logic [3:0]         A,
    output logic [3:0]         B,
    output logic               Cin,
    output logic               S,
    output logic               valid,
    output logic [PHASE_W-1:0] phase
);

    logic [3:0] sw_p0, sw_p1;
    logic       cin_p0, cin_p1;
    logic       sel_p0, sel_p1;

    logic enter_press;
    logic clear_press;

    phase_t     state, state_nx;
    logic [3:0] a_nx, b_nx;
    logic       cin_nx, s_nx;

    // Switch synchronizers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_p0  <= '0;
            sw_p1  <= '0;
            cin_p0 <= 1'b0;
            cin_p1 <= 1'b0;
            sel_p0 <= 1'b0;
            sel_p1 <= 1'b0;
        end else begin
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
            cin_p0 <= cin_sw;
            cin_p1 <= cin_p0;
            sel_p0 <= sel_sw;
            sel_p1 <= sel_p0;
        end
    end

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_enter),
        .level (),
        .press (enter_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_clear),
        .level (),
        .press (clear_press)
    );

    always_comb begin
        state_nx = state;
        a_nx     = A;
        b_nx     = B;
        cin_nx   = Cin;
        s_nx     = S;
        // Clear is checked first so a coincident enter captures nothing.
        if (clear_press) begin
            state_nx = LOAD_A;
            a_nx     = '0;
            b_nx     = '0;
            cin_nx   = 1'b0;
            s_nx     = 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (enter_press) begin
                        a_nx     = sw_p1;
                        state_nx = LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (enter_press) begin
                        b_nx     = sw_p1;
                        cin_nx   = cin_p1;
                        s_nx     = sel_p1;
                        state_nx = READY;
                    end
                end
                READY: begin
                    // B/Cin/S are kept; only A is replaced.
                    if (enter_press) begin
                        a_nx     = sw_p1;
                        state_nx = LOAD_B;
                    end
                end
                default: state_nx = LOAD_A;
            endcase
        end
    end

    // FSM and operand registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            A     <= '0;
            B     <= '0;
            Cin   <= 1'b0;
            S     <= 1'b0;
            valid <= 1'b0;
        end else begin
            state <= state_nx;
            A     <= a_nx;
            B     <= b_nx;
            Cin   <= cin_nx;
            S     <= s_nx;
            // Registered from the next state so valid rises with the B capture.
            valid <= (state_nx == READY);
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_operand_entry.sv
`timescale 1ns/1ps
module tb_operand_entry;

    localparam int DEB = 4;
    // Capture edge counted from the edge after which the raw button rises.
    localparam int CAP_EDGE = DEB + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       cin_sw, sel_sw, btn_enter, btn_clear;
    logic [3:0] A, B;
    logic       Cin, S, valid;
    logic [1:0] phase;

    int n_checks = 0;
    int n_fail   = 0;

    // Abstract model of the entered operand set.
    logic [3:0] exp_a, exp_b;
    logic       exp_cin, exp_s;
    logic [1:0] exp_ph;

    operand_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .cin_sw    (cin_sw),
        .sel_sw    (sel_sw),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .S         (S),
        .valid     (valid),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        exp_a = 0; exp_b = 0; exp_cin = 0; exp_s = 0; exp_ph = 0;
    endfunction

    function automatic void model_enter(input logic [3:0] s4, input logic c, input logic sl);
        case (exp_ph)
            2'd0: begin exp_a = s4; exp_ph = 2'd1; end
            2'd1: begin exp_b = s4; exp_cin = c; exp_s = sl; exp_ph = 2'd2; end
            default: begin exp_a = s4; exp_ph = 2'd1; end
        endcase
    endfunction

    function automatic logic [14:0] model_vec();
        return {exp_a, exp_b, exp_cin, exp_s, (exp_ph == 2'd2), exp_ph};
    endfunction

    // press and hold, then release and let the debouncer settle
    task automatic hold_release(input logic en, input logic cl, input int hold);
        btn_enter = en;
        btn_clear = cl;
        tick(hold);
        btn_enter = 0;
        btn_clear = 0;
        tick(10);
    endtask

    task automatic test_reset();
        logic [14:0] got;
        got = {A, B, Cin, S, valid, phase};
        n_checks++;
        if (got !== 15'd0) begin
            n_fail++; $display("FAIL reset_initial: got %h expected %h", got, 15'd0);
        end
        @(posedge clk); #1 rst_n = 1;
        tick(2);
        sw = 4'h9;
        model_enter(4'h9, 0, 0);
        hold_release(1, 0, 10);
        n_checks++;
        if (A !== 4'h9 || phase !== 2'd1) begin
            n_fail++; $display("FAIL reset_preload: got A=%h phase=%0d expected A=9 phase=1", A, phase);
        end
        #2 rst_n = 0;
        #1;
        model_clear();
        got = {A, B, Cin, S, valid, phase};
        n_checks++;
        if (got !== 15'd0) begin
            n_fail++; $display("FAIL reset_async: got %h expected %h", got, 15'd0);
        end
        sw = 0;
        @(posedge clk); #1 rst_n = 1;
        tick(2);
    endtask

    task automatic test_full_entry();
        sw = 4'h7;
        btn_enter = 1;
        tick(CAP_EDGE - 1);
        n_checks++;
        if (A !== 4'h0 || phase !== 2'd0) begin
            n_fail++; $display("FAIL entry_a_early: got A=%h phase=%0d expected A=0 phase=0", A, phase);
        end
        tick(1);
        n_checks++;
        if (A !== 4'h7 || phase !== 2'd1 || valid !== 1'b0) begin
            n_fail++; $display("FAIL entry_a_edge: got A=%h phase=%0d valid=%b expected A=7 phase=1 valid=0", A, phase, valid);
        end
        model_enter(4'h7, 0, 0);
        hold_release(1, 0, 10 - CAP_EDGE);
        sw = 4'h5; cin_sw = 1; sel_sw = 0;
        btn_enter = 1;
        tick(CAP_EDGE - 1);
        n_checks++;
        if (valid !== 1'b0 || phase !== 2'd1 || B !== 4'h0) begin
            n_fail++; $display("FAIL entry_b_early: got B=%h valid=%b phase=%0d expected B=0 valid=0 phase=1", B, valid, phase);
        end
        tick(1);
        model_enter(4'h5, 1, 0);
        n_checks++;
        if ({A, B, Cin, S, valid, phase} !== model_vec()) begin
            n_fail++; $display("FAIL entry_b_edge: got %h expected %h", {A, B, Cin, S, valid, phase}, model_vec());
        end
        hold_release(1, 0, 10 - CAP_EDGE);
    endtask

    task automatic test_reentry();
        sw = 4'hC; cin_sw = 0; sel_sw = 1;
        model_enter(4'hC, 0, 1);
        hold_release(1, 0, 10);
        n_checks++;
        if (A !== 4'hC || B !== 4'h5 || Cin !== 1'b1 || S !== 1'b0 || valid !== 1'b0 || phase !== 2'd1) begin
            n_fail++; $display("FAIL reentry: got A=%h B=%h Cin=%b S=%b valid=%b phase=%0d expected A=c B=5 Cin=1 S=0 valid=0 phase=1",
                               A, B, Cin, S, valid, phase);
        end
    endtask

    task automatic test_clear_priority();
        sw = 4'hE; cin_sw = 0; sel_sw = 1;
        model_clear();
        hold_release(1, 1, 10);
        n_checks++;
        if ({A, B, Cin, S, valid, phase} !== model_vec()) begin
            n_fail++; $display("FAIL clear_priority: got %h expected %h", {A, B, Cin, S, valid, phase}, model_vec());
        end
    endtask

    task automatic test_bounce();
        logic [6:0] pat;
        pat = 7'b1010110;
        sw = 4'hF;
        for (int i = 6; i >= 0; i--) begin
            btn_enter = pat[i];
            tick(1);
        end
        btn_enter = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            n_checks++;
            if (phase !== 2'd0 || A !== 4'h0) begin
                n_fail++; $display("FAIL bounce cycle %0d: got phase=%0d A=%h expected phase=0 A=0", i, phase, A);
            end
        end
    endtask

    task automatic test_long_hold();
        sw = 4'h3;
        btn_enter = 1;
        for (int i = 1; i <= 50; i++) begin
            tick(1);
            n_checks++;
            if (i < CAP_EDGE) begin
                if (phase !== 2'd0 || A !== 4'h0) begin
                    n_fail++; $display("FAIL long_hold edge %0d: got phase=%0d A=%h expected phase=0 A=0", i, phase, A);
                end
            end else if (phase !== 2'd1 || A !== 4'h3) begin
                n_fail++; $display("FAIL long_hold edge %0d: got phase=%0d A=%h expected phase=1 A=3", i, phase, A);
            end
        end
        model_enter(4'h3, 0, 0);
        hold_release(0, 0, 2);
        n_checks++;
        if ({A, B, Cin, S, valid, phase} !== model_vec()) begin
            n_fail++; $display("FAIL long_hold_final: got %h expected %h", {A, B, Cin, S, valid, phase}, model_vec());
        end
    endtask

    task automatic test_random();
        int         op, hold, run;
        logic [3:0] s4;
        logic       c, sl, on_clear;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 7);
            // idle switch wiggling before the press has no effect
            for (int k = 0; k < 3; k++) begin
                sw = 4'($urandom); cin_sw = 1'($urandom); sel_sw = 1'($urandom);
                tick(1);
            end
            s4 = 4'($urandom); c = 1'($urandom); sl = 1'($urandom);
            sw = s4; cin_sw = c; sel_sw = sl;
            if (op == 0) begin
                model_clear();
                hold_release(0, 1, $urandom_range(CAP_EDGE + 1, 14));
            end else if (op == 1) begin
                // bounce: runs of high samples never reach DEB
                on_clear = 1'($urandom);
                for (int k = 0; k < 4; k++) begin
                    run = $urandom_range(1, DEB - 1);
                    if (on_clear) btn_clear = 1; else btn_enter = 1;
                    tick(run);
                    btn_clear = 0; btn_enter = 0;
                    tick(1);
                end
                tick(10);
            end else begin
                model_enter(s4, c, sl);
                hold = $urandom_range(CAP_EDGE + 1, 14);
                btn_enter = 1;
                tick(CAP_EDGE);
                // switch changes after the capture edge are ignored
                for (int k = CAP_EDGE; k < hold; k++) begin
                    sw = 4'($urandom); cin_sw = 1'($urandom); sel_sw = 1'($urandom);
                    tick(1);
                end
                hold_release(0, 0, 1);
            end
            n_checks++;
            if ({A, B, Cin, S, valid, phase} !== model_vec()) begin
                n_fail++; $display("FAIL random op %0d kind %0d: got %h expected %h", it, op, {A, B, Cin, S, valid, phase}, model_vec());
            end
        end
    endtask

    initial begin
        rst_n = 0;
        sw = 0; cin_sw = 0; sel_sw = 0; btn_enter = 0; btn_clear = 0;
        model_clear();
        #1;
        test_reset();
        test_full_entry();
        test_reentry();
        test_clear_priority();
        test_bounce();
        test_long_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
